// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath encodings: PCMUX and ADDR2MUX selects, BR opcode, default reset PC.
package lc3_pkg;

    typedef enum logic [1:0] {
        PCMUX_INC  = 2'd0,
        PCMUX_BUS  = 2'd1,
        PCMUX_ADDR = 2'd2,
        PCMUX_HOLD = 2'd3
    } pcmux_e;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'd0,
        ADDR2_OFF6  = 2'd1,
        ADDR2_OFF9  = 2'd2,
        ADDR2_OFF11 = 2'd3
    } addr2_e;

    localparam logic [3:0]  OPCODE_BR        = 4'b0000;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;

endpackage

// File: rtl/lc3_addr_adder.sv
// LC-3 address adder: selects base (PC or BaseR) and a sign-extended IR offset, sums modulo 2^WIDTH.
// Shared between the PCMUX and MARMUX paths; IR field positions assume WIDTH == 16.
module lc3_addr_adder
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] base_reg,
    input  logic [WIDTH-1:0] ir,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    output logic [WIDTH-1:0] addr_out
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] offset;

    always_comb begin
        base   = addr1_sel ? base_reg : pc;
        offset = '0;
        case (addr2_e'(addr2_sel))
            ADDR2_ZERO:  offset = '0;
            ADDR2_OFF6:  offset = {{(WIDTH-6){ir[5]}},   ir[5:0]};
            ADDR2_OFF9:  offset = {{(WIDTH-9){ir[8]}},   ir[8:0]};
            ADDR2_OFF11: offset = {{(WIDTH-11){ir[10]}}, ir[10:0]};
            default:     offset = '0;
        endcase
        // Carry out is intentionally dropped so addresses wrap around the 64K space.
        addr_out = base + offset;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// LC-3 PC / BEN stage: PC register, branch-enable latch and address adder.
// Define BRANCH_STATS_EN to build the saturating BR evaluated/taken counters.
module pc_branch_unit
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ir,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    input  logic             ld_ben,
    input  logic             ld_pc,
    input  logic [1:0]       pc_mux,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic [WIDTH-1:0] base_reg,
    input  logic [WIDTH-1:0] buss,
    output logic [WIDTH-1:0] pc,
    output logic             ben,
    output logic [WIDTH-1:0] addr_out,
    output logic [15:0]      br_count,
    output logic [15:0]      br_taken
);

    logic             ben_next;
    logic [WIDTH-1:0] pc_next;

    lc3_addr_adder #(.WIDTH(WIDTH)) u_addr_adder (
        .pc        (pc),
        .base_reg  (base_reg),
        .ir        (ir),
        .addr1_sel (addr1_sel),
        .addr2_sel (addr2_sel),
        .addr_out  (addr_out)
    );

    // Flags are the already-registered n/z/p, so a same-cycle CC update is seen one cycle later.
    assign ben_next = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

    always_comb begin
        pc_next = pc;
        case (pcmux_e'(pc_mux))
            PCMUX_INC:  pc_next = pc + 1'b1;
            PCMUX_BUS:  pc_next = buss;
            PCMUX_ADDR: pc_next = addr_out;
            PCMUX_HOLD: pc_next = pc;
            default:    pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_PC[WIDTH-1:0];
            ben <= 1'b0;
        end else begin
            if (ld_pc)
                pc <= pc_next;
            if (ld_ben)
                ben <= ben_next;
        end
    end

`ifdef BRANCH_STATS_EN
    logic is_br_eval;

    assign is_br_eval = ld_ben && (ir[15:12] == OPCODE_BR);

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count <= '0;
            br_taken <= '0;
        end else if (is_br_eval) begin
            if (br_count != 16'hFFFF)
                br_count <= br_count + 16'd1;
            if (ben_next && (br_taken != 16'hFFFF))
                br_taken <= br_taken + 16'd1;
        end
    end
`else
    logic unused_stats_opcode;

    assign unused_stats_opcode = ^ir[15:12];
    assign br_count = '0;
    assign br_taken = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit; counter expectations follow BRANCH_STATS_EN.
module tb_pc_branch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic        n, z, p;
    logic        ld_ben;
    logic        ld_pc;
    logic [1:0]  pc_mux;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic [15:0] base_reg;
    logic [15:0] buss;
    logic [15:0] pc;
    logic        ben;
    logic [15:0] addr_out;
    logic [15:0] br_count;
    logic [15:0] br_taken;

    int errors = 0;
    int checks = 0;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int expCount = 0;
    int expTaken = 0;

    pc_branch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .n         (n),
        .z         (z),
        .p         (p),
        .ld_ben    (ld_ben),
        .ld_pc     (ld_pc),
        .pc_mux    (pc_mux),
        .addr1_sel (addr1_sel),
        .addr2_sel (addr2_sel),
        .base_reg  (base_reg),
        .buss      (buss),
        .pc        (pc),
        .ben       (ben),
        .addr_out  (addr_out),
        .br_count  (br_count),
        .br_taken  (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkStats(input string tag);
        logic [15:0] ec;
        logic [15:0] et;
        ec = STATS ? 16'(expCount) : 16'h0000;
        et = STATS ? 16'(expTaken) : 16'h0000;
        checkOutput({tag, "_count"}, br_count, ec);
        checkOutput({tag, "_taken"}, br_taken, et);
    endtask

    initial begin
        reset = 1'b1; ir = 16'h0E00; n = 1'b1; z = 1'b0; p = 1'b0;
        ld_ben = 1'b1; ld_pc = 1'b1; pc_mux = 2'd1; addr1_sel = 1'b0; addr2_sel = 2'd0;
        base_reg = 16'h0000; buss = 16'h1234;

        // Reset must override ld_pc/ld_ben
        applyStimulus();
        applyStimulus();
        checkOutput("reset_pc", pc, 16'h3000);
        checkOutput("reset_ben", {15'd0, ben}, 16'h0000);
        checkStats("reset");

        reset = 1'b0; ld_ben = 1'b0; ld_pc = 1'b1; pc_mux = 2'd0;
        applyStimulus();
        checkOutput("inc_after_reset", pc, 16'h3001);

        // BRnp #5 with Z only, then with P
        ld_pc = 1'b0; ir = 16'h0A05; n = 1'b0; z = 1'b1; p = 1'b0; ld_ben = 1'b1;
        applyStimulus();
        expCount += 1;
        checkOutput("brnp_z", {15'd0, ben}, 16'h0000);
        p = 1'b1; z = 1'b0;
        applyStimulus();
        expCount += 1; expTaken += 1;
        checkOutput("brnp_p", {15'd0, ben}, 16'h0001);

        ld_ben = 1'b0; ld_pc = 1'b1; pc_mux = 2'd2; addr1_sel = 1'b0; addr2_sel = 2'd2;
        #1;
        checkOutput("addr_off9", addr_out, 16'h3006);
        applyStimulus();
        checkOutput("pc_branch", pc, 16'h3006);

        // Wrap-around on adder and incrementer
        pc_mux = 2'd1; buss = 16'h0000;
        applyStimulus();
        checkOutput("pc_from_bus", pc, 16'h0000);
        ir = 16'h01FF; ld_pc = 1'b0; addr1_sel = 1'b0; addr2_sel = 2'd2;
        #1;
        checkOutput("addr_neg1", addr_out, 16'hFFFF);
        ld_pc = 1'b1; pc_mux = 2'd2;
        applyStimulus();
        checkOutput("pc_ffff", pc, 16'hFFFF);
        pc_mux = 2'd0;
        applyStimulus();
        checkOutput("pc_wrap", pc, 16'h0000);

        // JMP/JSRR base register path, then offset11 and offset6
        addr1_sel = 1'b1; addr2_sel = 2'd0; base_reg = 16'h4000; pc_mux = 2'd2;
        applyStimulus();
        checkOutput("pc_jmp", pc, 16'h4000);
        pc_mux = 2'd1; buss = 16'h3000;
        applyStimulus();
        ld_pc = 1'b0; ir = 16'h0400; addr1_sel = 1'b0; addr2_sel = 2'd3;
        #1;
        checkOutput("addr_off11", addr_out, 16'h2C00);
        ir = 16'h0020; addr2_sel = 2'd1;
        #1;
        checkOutput("addr_off6", addr_out, 16'h2FE0);

        // ir[11:9]=000 never taken, for every flag combination
        ir = 16'h0000; ld_ben = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {n, z, p} = 3'(i);
            applyStimulus();
            expCount += 1;
            checkOutput($sformatf("never_taken_%0d", i), {15'd0, ben}, 16'h0000);
        end
        ld_ben = 1'b0;

        ld_pc = 1'b1; pc_mux = 2'd3;
        applyStimulus();
        checkOutput("pc_hold_mux3", pc, 16'h3000);
        ld_pc = 1'b0; pc_mux = 2'd1; buss = 16'h5555;
        applyStimulus();
        checkOutput("pc_hold_ldpc0", pc, 16'h3000);

        // ld_pc and ld_ben together: BRnzp #7
        ir = 16'h0E07; n = 1'b1; z = 1'b0; p = 1'b0; ld_ben = 1'b1; ld_pc = 1'b1;
        pc_mux = 2'd2; addr1_sel = 1'b0; addr2_sel = 2'd2;
        applyStimulus();
        expCount += 1; expTaken += 1;
        checkOutput("both_pc", pc, 16'h3007);
        checkOutput("both_ben", {15'd0, ben}, 16'h0001);
        checkStats("br_evals");

        // Non-BR opcode updates ben but not the counters
        ld_pc = 1'b0; ir = 16'h1E00; n = 1'b0; z = 1'b0; p = 1'b0;
        applyStimulus();
        checkOutput("nonbr_ben", {15'd0, ben}, 16'h0000);
        checkStats("nonbr");

        // Mid-instruction reset clears everything
        ld_pc = 1'b1; pc_mux = 2'd1; buss = 16'hBEEF; ir = 16'h0E00; n = 1'b1; reset = 1'b1;
        applyStimulus();
        reset = 1'b0; ld_pc = 1'b0; ld_ben = 1'b0;
        expCount = 0; expTaken = 0;
        checkOutput("midreset_pc", pc, 16'h3000);
        checkOutput("midreset_ben", {15'd0, ben}, 16'h0000);
        checkStats("midreset");

        // Drive counters past saturation with taken BRs
        ld_ben = 1'b1; ir = 16'h0E00; n = 1'b1;
        for (int i = 0; i < 65540; i++) applyStimulus();
        ld_ben = 1'b0;
        expCount = 16'hFFFF; expTaken = 16'hFFFF;
        checkStats("saturate");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
